read_descrambler: RTL

READ_DESCRAMBLER -- requirements
Module: read_descrambler

---
 rtl/read_descrambler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/read_descrambler.sv
// Read-path command/data forwarder with per-lane LFSR8 descrambling.
// Local config commands set the enable and row seed for page/spare read-backs.
module read_descrambler #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int ThisID = 3,
  parameter logic [5:0] DispatchCmd_PageWriteToRAM = 6'b000100,
  parameter logic [5:0] DispatchCmd_SpareWriteToRAM = 6'b000101
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [5:0]                    iSrcOpcode,
  input  logic [4:0]                    iSrcTargetID,
  input  logic [4:0]                    iSrcSourceID,
  input  logic [AddressWidth-1:0]       iSrcAddress,
  input  logic [InnerIFLengthWidth-1:0] iSrcLength,
  input  logic                          iSrcCmdValid,
  output logic                          oSrcCmdReady,
  output logic [5:0]                    oDstOpcode,
  output logic [4:0]                    oDstTargetID,
  output logic [4:0]                    oDstSourceID,
  output logic [AddressWidth-1:0]       oDstAddress,
  output logic [InnerIFLengthWidth-1:0] oDstLength,
  output logic                          oDstCmdValid,
  input  logic                          iDstCmdReady,
  input  logic [DataWidth-1:0]          iSrcReadData,
  input  logic                          iSrcReadValid,
  input  logic                          iSrcReadLast,
  output logic                          oSrcReadReady,
  output logic [DataWidth-1:0]          oDstReadData,
  output logic                          oDstReadValid,
  output logic                          oDstReadLast,
  input  logic                          iDstReadReady,
  output logic                          oLenMismatch
);

  localparam int Lanes = DataWidth / 8;
  localparam int LaneBits = (Lanes > 1) ? $clog2(Lanes) : 1;

  typedef enum logic [2:0] {
    Idle,
    BypassCmd,
    BypassTrf,
    DecTrfCmd,
    DecTrf
  } state_t;

  state_t state, stateNext;

  logic [5:0]                    opcode;
  logic [4:0]                    targetID;
  logic [4:0]                    sourceID;
  logic [AddressWidth-1:0]       address;
  logic [InnerIFLengthWidth-1:0] length;
  logic [AddressWidth-1:0]       rowAddress;
  logic                          decEnable;
  logic [InnerIFLengthWidth-1:0] beatCnt;
  logic                          lenMismatch;
  logic [DataWidth-1:0]          keystream;

  logic isTrf;
  logic cmdFire;
  logic isLocal;
  logic isDec;
  logic beatFire;
  logic lastFire;
  logic trfEntry;

  assign isTrf = (state == BypassTrf) || (state == DecTrf);
  assign cmdFire = (state == Idle) && iSrcCmdValid;
  assign isLocal = iSrcTargetID == 5'(ThisID);
  assign isDec = decEnable && (iSrcTargetID == 5'd0) &&
                 ((iSrcOpcode == DispatchCmd_PageWriteToRAM) ||
                  (iSrcOpcode == DispatchCmd_SpareWriteToRAM));
  assign beatFire = isTrf && iSrcReadValid && iDstReadReady;
  assign lastFire = beatFire && iSrcReadLast;
  assign trfEntry = ((state == BypassCmd) || (state == DecTrfCmd)) &&
                    iDstCmdReady;

  always_ff @(posedge iClock) begin
    if (iReset) state <= Idle;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle: begin
        if (iSrcCmdValid && !isLocal) begin
          if (isDec) stateNext = DecTrfCmd;
          else stateNext = BypassCmd;
        end
      end
      BypassCmd: begin
        if (iDstCmdReady) begin
          if (length == '0) stateNext = Idle;
          else stateNext = BypassTrf;
        end
      end
      DecTrfCmd: begin
        if (iDstCmdReady) stateNext = DecTrf;
      end
      BypassTrf, DecTrf: begin
        if (lastFire) stateNext = Idle;
      end
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      opcode      <= '0;
      targetID    <= '0;
      sourceID    <= '0;
      address     <= '0;
      length      <= '0;
      rowAddress  <= '0;
      decEnable   <= 1'b1;
      beatCnt     <= '0;
      lenMismatch <= 1'b0;
    end else begin
      if (cmdFire) begin
        opcode   <= iSrcOpcode;
        targetID <= iSrcTargetID;
        sourceID <= iSrcSourceID;
        address  <= iSrcAddress;
        length   <= iSrcLength;
        if (isLocal) begin
          if (iSrcOpcode == 6'b000001) decEnable <= 1'b0;
          else if (iSrcOpcode == 6'b000011) decEnable <= 1'b1;
          else rowAddress <= iSrcAddress;
        end
      end
      if (trfEntry) beatCnt <= '0;
      else if (beatFire) beatCnt <= beatCnt + 1'b1;
      if (lastFire && ((beatCnt + 1'b1) != length)) lenMismatch <= 1'b1;
    end
  end

  // Each lane reseeds while the command waits and steps once per accepted beat.
  for (genvar i = 0; i < Lanes; i++) begin : gLane
    logic [7:0] lfsr;
    logic [7:0] seed;
    logic       fb;

    assign seed = 8'({rowAddress, LaneBits'(i)});
    assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign keystream[8*i +: 8] = lfsr;

    always_ff @(posedge iClock) begin
      if (iReset) lfsr <= 8'hFF;
      else if (state == DecTrfCmd) lfsr <= seed;
      else if ((state == DecTrf) && beatFire) lfsr <= {lfsr[6:0], fb};
    end
  end

  assign oSrcCmdReady = state == Idle;
  assign oDstCmdValid = (state == BypassCmd) || (state == DecTrfCmd);
  assign oDstOpcode   = opcode;
  assign oDstTargetID = targetID;
  assign oDstSourceID = sourceID;
  assign oDstAddress  = address;
  assign oDstLength   = length;

  assign oDstReadValid = isTrf && iSrcReadValid;
  assign oSrcReadReady = isTrf && iDstReadReady;
  assign oDstReadLast  = iSrcReadLast;
  assign oDstReadData  = (state == DecTrf) ? (iSrcReadData ^ keystream)
                                           : iSrcReadData;
  assign oLenMismatch  = lenMismatch;

endmodule
